mips_mc_control: RTL

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mips_mc_control_if.sv | 36 +++
 rtl/mips_alu_decode.sv | 25 ++
 rtl/mips_mc_control.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode/funct
// constants, ALU and mux select encodings, and the controller state enum.
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpAddi  = 6'h08;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;

    // ALU OP port encoding
    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluAnd = 2'b01;
    localparam logic [1:0] AluOr  = 2'b10;
    localparam logic [1:0] AluSub = 2'b11;

    // ALU B-input mux
    localparam logic [1:0] SrcBRegB  = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    // PC source mux
    localparam logic [1:0] PcAluRes = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11,
        StHalt     = 4'd12
    } state_e;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-unit bus: instruction fields and status in, datapath controls out.
//   master : drives opcode/funct/zero/mem_ready, observes controls
//   slave  : the control unit itself
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic [3:0] state_dbg;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_source, pc_en, ir_write, mem_read,
               mem_write, iord, reg_write, reg_dst, mem_to_reg, halted, state_dbg
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_source, pc_en, ir_write, mem_read,
               mem_write, iord, reg_write, reg_dst, mem_to_reg, halted, state_dbg
    );
endinterface

// File: rtl/mips_alu_decode.sv
// R-type funct to ALU operation decoder (combinational).
//   funct   : IR[5:0]
//   alu_op  : ALU OP port encoding (add for unknown funct)
//   illegal : funct is not one of add/sub/and/or
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [1:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = AluAdd;
        illegal = 1'b0;
        unique case (funct)
            FnAdd:   alu_op = AluAdd;
            FnSub:   alu_op = AluSub;
            FnAnd:   alu_op = AluAnd;
            FnOr:    alu_op = AluOr;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS controller (Moore FSM) for lw/sw/R-type/beq/j/addi.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, returns to FETCH
//   bus   : slave side of mips_mc_control_if (instruction fields, zero,
//           mem_ready in; datapath controls, halted, state_dbg out)
// HALT_ON_ILLEGAL: 1 parks in HALT on an unknown opcode/funct, 0 skips it.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    mips_mc_control_if.slave bus
);

    localparam state_e IllegalSt = HALT_ON_ILLEGAL ? StHalt : StFetch;

    state_e     state_q, state_d;
    logic [1:0] fn_alu_op;
    logic       fn_illegal;

    mips_alu_decode u_alu_decode (
        .funct   (bus.funct),
        .alu_op  (fn_alu_op),
        .illegal (fn_illegal)
    );

    // Illegal funct is caught in DECODE so a bad R-type never reaches R_EXEC.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (bus.opcode)
                    OpRType:     state_d = fn_illegal ? IllegalSt : StRExec;
                    OpLw, OpSw:  state_d = StMemAddr;
                    OpBeq:       state_d = StBranch;
                    OpJ:         state_d = StJump;
                    OpAddi:      state_d = StAddiExec;
                    default:     state_d = IllegalSt;
                endcase
            end
            StMemAddr:  state_d = (bus.opcode == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  if (bus.mem_ready) state_d = StMemWb;
            StMemWrite: if (bus.mem_ready) state_d = StFetch;
            StRExec:    state_d = StRWb;
            StAddiExec: state_d = StAddiWb;
            StHalt:     state_d = StHalt;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StFetch;
        else        state_q <= state_d;
    end

    // Outputs follow state_q; pc_en (FETCH/BRANCH) and alu_op (R_EXEC) also
    // look at live inputs.
    always_comb begin
        bus.alu_op     = AluAdd;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SrcBRegB;
        bus.pc_source  = PcAluRes;
        bus.pc_en      = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.halted     = 1'b0;
        unique case (state_q)
            StFetch: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SrcBFour;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
            end
            StDecode:   bus.alu_src_b = SrcBImmSh;
            StMemAddr, StAddiExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SrcBImm;
            end
            StMemRead: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            StRExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = fn_alu_op;
            end
            StRWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            StBranch: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = AluSub;
                bus.pc_source = PcAluOut;
                bus.pc_en     = bus.zero;
            end
            StJump: begin
                bus.pc_source = PcJump;
                bus.pc_en     = 1'b1;
            end
            StAddiWb:   bus.reg_write = 1'b1;
            StHalt:     bus.halted = 1'b1;
            default: ;
        endcase
        // Reset masks every enable immediately, even mid-access.
        if (!rst_n) begin
            bus.pc_en     = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
            bus.halted    = 1'b0;
        end
    end

    assign bus.state_dbg = state_q;

endmodule
